// File: rtl/sdi_crop_cfg_ctrl.sv
// Crop-window shadow/commit controller and frame-aligned run/stop sequencer for the SDI-to-AXIS converter.
// Registered outputs; window changes take effect in IDLE or at a vertical-active falling edge only.
module sdi_crop_cfg_ctrl #(
  parameter int MAX_W = 1920,
  parameter int MAX_H = 1080
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_en,
  input  logic [1:0]  i_wr_addr,
  input  logic [15:0] i_wr_data,
  input  logic        i_commit,
  input  logic        i_enable,
  input  logic        i_frame_vs,
  input  logic        i_frame_last,
  output logic [15:0] o_image_w,
  output logic [15:0] o_image_h,
  output logic [15:0] o_offset_x,
  output logic [15:0] o_offset_y,
  output logic        o_cmr_vld,
  output logic        o_commit_pend,
  output logic        o_cfg_err,
  output logic        o_frame_err,
  output logic [15:0] o_frame_cnt,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, STOP = 2'd3} state_t;

  state_t      state;
  logic [15:0] sh_w, sh_h, sh_x, sh_y;
  logic [15:0] pend_w, pend_h, pend_x, pend_y;
  logic [15:0] line_cnt;
  logic        vs_d;
  logic        first_frame;

  logic        vs_fall, vs_rise, cfg_ok;
  logic [16:0] sum_x, sum_y;

  assign vs_fall = vs_d & ~i_frame_vs;
  assign vs_rise = ~vs_d & i_frame_vs;
  assign sum_x   = {1'b0, sh_x} + {1'b0, sh_w};
  assign sum_y   = {1'b0, sh_y} + {1'b0, sh_h};
  // Width must be even: 4:2:2 carries chroma in pixel pairs.
  assign cfg_ok  = (sh_w != 16'd0) && (sh_h != 16'd0) && !sh_w[0] &&
                   (sum_x <= 17'(MAX_W)) && (sum_y <= 17'(MAX_H));
  assign o_state = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      sh_w          <= 16'(MAX_W);
      sh_h          <= 16'(MAX_H);
      sh_x          <= '0;
      sh_y          <= '0;
      pend_w        <= '0;
      pend_h        <= '0;
      pend_x        <= '0;
      pend_y        <= '0;
      o_image_w     <= 16'(MAX_W);
      o_image_h     <= 16'(MAX_H);
      o_offset_x    <= '0;
      o_offset_y    <= '0;
      o_cmr_vld     <= 1'b0;
      o_commit_pend <= 1'b0;
      o_cfg_err     <= 1'b0;
      o_frame_err   <= 1'b0;
      o_frame_cnt   <= '0;
      line_cnt      <= '0;
      vs_d          <= 1'b0;
      first_frame   <= 1'b0;
    end else begin
      vs_d <= i_frame_vs;

      if (i_wr_en) begin
        case (i_wr_addr)
          2'd0: sh_w <= i_wr_data;
          2'd1: sh_h <= i_wr_data;
          2'd2: sh_x <= i_wr_data;
          default: sh_y <= i_wr_data;
        endcase
      end

      if (o_commit_pend && (state == IDLE || vs_fall)) begin
        o_image_w     <= pend_w;
        o_image_h     <= pend_h;
        o_offset_x    <= pend_x;
        o_offset_y    <= pend_y;
        o_commit_pend <= 1'b0;
      end

      // A new commit never displaces the set being applied this edge; it waits for the next blanking.
      if (i_commit) begin
        if (!cfg_ok) begin
          o_cfg_err <= 1'b1;
        end else begin
          o_cfg_err <= 1'b0;
          if (state == IDLE) begin
            o_image_w     <= sh_w;
            o_image_h     <= sh_h;
            o_offset_x    <= sh_x;
            o_offset_y    <= sh_y;
            o_commit_pend <= 1'b0;
          end else begin
            pend_w        <= sh_w;
            pend_h        <= sh_h;
            pend_x        <= sh_x;
            pend_y        <= sh_y;
            o_commit_pend <= 1'b1;
          end
        end
      end

      o_frame_err <= 1'b0;
      if (state == RUN || state == STOP) begin
        if (vs_rise)
          line_cnt <= i_frame_last ? 16'd1 : 16'd0;
        else if (i_frame_last)
          line_cnt <= line_cnt + 16'd1;
        if (vs_fall) begin
          if (!first_frame && line_cnt != o_image_h)
            o_frame_err <= 1'b1;
          o_frame_cnt <= o_frame_cnt + 16'd1;
          first_frame <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          o_cmr_vld <= 1'b0;
          if (i_enable) state <= ARM;
        end
        ARM: begin
          if (!i_enable) begin
            state <= IDLE;
          end else if (!i_frame_vs) begin
            state       <= RUN;
            o_cmr_vld   <= 1'b1;
            first_frame <= 1'b1;
          end
        end
        RUN: begin
          if (!i_enable) state <= STOP;
        end
        default: begin
          if (i_enable) begin
            state <= RUN;
          end else if (!i_frame_vs) begin
            state     <= IDLE;
            o_cmr_vld <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdi_crop_cfg_ctrl.sv
// Directed bench for sdi_crop_cfg_ctrl: window commit/validation, run/stop sequencing and line checks.
module tb_sdi_crop_cfg_ctrl;
  logic        clk = 1'b0;
  logic        rst, wr_en, commit, enable, frame_vs, frame_last;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] image_w, image_h, offset_x, offset_y, frame_cnt;
  logic        cmr_vld, commit_pend, cfg_err, frame_err;
  logic [1:0]  state;

  int total = 0;
  int bad = 0;

  sdi_crop_cfg_ctrl #(.MAX_W(1920), .MAX_H(1080)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_commit(commit), .i_enable(enable), .i_frame_vs(frame_vs), .i_frame_last(frame_last),
    .o_image_w(image_w), .o_image_h(image_h), .o_offset_x(offset_x), .o_offset_y(offset_y),
    .o_cmr_vld(cmr_vld), .o_commit_pend(commit_pend), .o_cfg_err(cfg_err),
    .o_frame_err(frame_err), .o_frame_cnt(frame_cnt), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic frame_body(input int lines);
    frame_vs = 1'b1;
    tick(); tick();
    for (int i = 0; i < lines; i++) begin
      frame_last = 1'b1;
      tick();
    end
    frame_last = 1'b0;
    tick();
  endtask

  // Ends right after the edge that sees vs fall; caller checks, then idles a blank cycle.
  task automatic run_frame(input int lines);
    frame_body(lines);
    frame_vs = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    enable = 1'b0; frame_vs = 1'b0; frame_last = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_w", image_w, 1920);
    chk("rst_h", image_h, 1080);
    chk("rst_x", offset_x, 0);
    chk("rst_y", offset_y, 0);
    chk("rst_cmr", cmr_vld, 0);
    chk("rst_pend", commit_pend, 0);
    chk("rst_cerr", cfg_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_state", state, 0);

    wr(2'd0, 16'd1280); wr(2'd1, 16'd720); wr(2'd2, 16'd320); wr(2'd3, 16'd180);
    chk("shadow_only_w", image_w, 1920);
    do_commit();
    chk("idle_w", image_w, 1280);
    chk("idle_h", image_h, 720);
    chk("idle_x", offset_x, 320);
    chk("idle_y", offset_y, 180);
    chk("idle_cerr", cfg_err, 0);
    chk("idle_pend", commit_pend, 0);

    wr(2'd0, 16'd1921); do_commit();
    chk("w1921_err", cfg_err, 1);
    chk("w1921_keep", image_w, 1280);
    wr(2'd0, 16'd1000); wr(2'd2, 16'd1000); do_commit();
    chk("xw_over_err", cfg_err, 1);
    chk("xw_over_keep_x", offset_x, 320);
    wr(2'd0, 16'd1279); wr(2'd2, 16'd320); do_commit();
    chk("odd_w_err", cfg_err, 1);
    wr(2'd0, 16'd1600); do_commit();
    chk("edge_sum_ok", cfg_err, 0);
    chk("edge_sum_w", image_w, 1600);
    wr(2'd0, 16'd1280); wr(2'd3, 16'd900); do_commit();
    chk("ysum_over_err", cfg_err, 1);
    wr(2'd3, 16'd180); do_commit();
    chk("recover_err", cfg_err, 0);
    chk("recover_w", image_w, 1280);

    wr(2'd1, 16'd540);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'd360; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    chk("samecyc_old", image_h, 540);
    do_commit();
    chk("samecyc_new", image_h, 360);
    wr(2'd1, 16'd720); do_commit();
    chk("h_back", image_h, 720);

    frame_vs = 1'b1; tick();
    enable = 1'b1; tick();
    chk("arm_state", state, 1);
    chk("arm_cmr", cmr_vld, 0);
    tick(); tick();
    chk("arm_hold_cmr", cmr_vld, 0);
    frame_vs = 1'b0; tick();
    chk("run_state", state, 2);
    chk("run_cmr", cmr_vld, 1);

    run_frame(100);
    chk("partial_ferr", frame_err, 0);
    chk("partial_fcnt", frame_cnt, 1);
    tick();
    run_frame(720);
    chk("full_ferr", frame_err, 0);
    chk("full_fcnt", frame_cnt, 2);
    tick();
    run_frame(719);
    chk("short_ferr", frame_err, 1);
    chk("short_fcnt", frame_cnt, 3);
    tick();
    chk("short_ferr_pulse", frame_err, 0);

    frame_vs = 1'b1; tick(); tick();
    wr(2'd1, 16'd540); do_commit();
    chk("mid_pend", commit_pend, 1);
    chk("mid_h_hold", image_h, 720);
    for (int i = 0; i < 720; i++) begin frame_last = 1'b1; tick(); end
    frame_last = 1'b0; tick();
    chk("mid_h_hold_end", image_h, 720);
    frame_vs = 1'b0; tick();
    chk("fall_h", image_h, 540);
    chk("fall_pend", commit_pend, 0);
    chk("fall_ferr_oldh", frame_err, 0);
    chk("fall_fcnt", frame_cnt, 4);
    tick();
    run_frame(540);
    chk("h540_ferr", frame_err, 0);
    chk("h540_fcnt", frame_cnt, 5);
    tick();

    frame_vs = 1'b1; tick(); tick();
    wr(2'd1, 16'd720); do_commit();
    wr(2'd1, 16'd600);
    for (int i = 0; i < 540; i++) begin frame_last = 1'b1; tick(); end
    frame_last = 1'b0; tick();
    frame_vs = 1'b0; commit = 1'b1; tick();
    commit = 1'b0;
    chk("fallcommit_h", image_h, 720);
    chk("fallcommit_pend", commit_pend, 1);
    chk("fallcommit_ferr", frame_err, 0);
    tick();
    chk("fallcommit_hold", image_h, 720);
    run_frame(720);
    chk("fallcommit_next_h", image_h, 600);
    chk("fallcommit_next_ferr", frame_err, 0);
    chk("fallcommit_fcnt", frame_cnt, 7);
    tick();

    frame_vs = 1'b1; tick(); tick();
    enable = 1'b0; tick();
    chk("stop_state", state, 3);
    chk("stop_cmr", cmr_vld, 1);
    for (int i = 0; i < 600; i++) begin frame_last = 1'b1; tick(); end
    frame_last = 1'b0; tick();
    chk("stop_cmr_hold", cmr_vld, 1);
    frame_vs = 1'b0; tick();
    chk("stop_idle", state, 0);
    chk("stop_cmr_off", cmr_vld, 0);
    chk("stop_ferr", frame_err, 0);
    chk("stop_fcnt", frame_cnt, 8);

    enable = 1'b1; tick(); tick();
    chk("blank_run", state, 2);
    enable = 1'b0; tick();
    chk("blank_stop", state, 3);
    tick();
    chk("blank_idle", state, 0);

    enable = 1'b1; tick(); tick();
    frame_body(10);
    frame_vs = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    chk("midrst_ferr", frame_err, 0);
    chk("midrst_fcnt", frame_cnt, 0);
    chk("midrst_state", state, 0);
    chk("midrst_h", image_h, 1080);
    chk("midrst_cmr", cmr_vld, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdi_crop_cfg_ctrl.md
# sdi_crop_cfg_ctrl

Run/stop sequencer and crop-window configuration controller for the SDI-to-AXI-Stream converter. Host writes land in shadow registers, are range-checked, and are committed to the active window (image_w/h, offset_x/y) only in vertical blanking, so a frame is never cropped with mixed settings. The block also drives the converter's camera-valid enable with frame-aligned start/stop and checks that each frame delivers the committed number of lines. It sits in the i_clk (SDI recovered clock) domain, between the host register bank and the converter.

## Interface
- MAX_W, 1920, active pixels per SDI line (upper bound for offset_x + w)
- MAX_H, 1080, active lines per SDI frame (upper bound for offset_y + h)
- i_clk  in  1  SDI pixel clock
- i_rst  in  1  reset i_rst, synchronous, active-high; clock i_clk
- i_wr_en  in  1  shadow register write strobe
- i_wr_addr  in  2  0=w, 1=h, 2=offset_x, 3=offset_y
- i_wr_data  in  16  write data
- i_commit  in  1  one-cycle request to validate and apply the shadow set
- i_enable  in  1  level; 1=capture requested, 0=stop requested
- i_frame_vs  in  1  converter vertical-active flag
- i_frame_last  in  1  converter per-line last-pixel strobe (m_last)
- o_image_w, o_image_h, o_offset_x, o_offset_y  out  16 each  active window, to converter
- o_cmr_vld  out  1  converter enable
- o_commit_pend  out  1  valid commit waiting for blanking
- o_cfg_err  out  1  sticky: last commit rejected
- o_frame_err  out  1  one-cycle pulse: line count mismatch at frame end
- o_frame_cnt  out  16  frames completed while in RUN, wraps
- o_state  out  2  0=IDLE, 1=ARM, 2=RUN, 3=STOP

## Operation
- Shadow regs: a write updates the addressed shadow register at the next edge. Shadow reset values: MAX_W, MAX_H, 0, 0.
- Validation on i_commit uses the shadow values from before any write in the same cycle. A same-cycle write goes to shadow only.
- Valid iff: w != 0, h != 0, w[0] == 0 (4:2:2 pairs), {1'b0,offset_x}+w <= MAX_W, {1'b0,offset_y}+h <= MAX_H. Sums are 17-bit, so there is no wrap.
- Invalid commit: set o_cfg_err, discard the request; any earlier pending commit stays pending.
- Valid commit: clear o_cfg_err; latch the set into a pending copy; set o_commit_pend. A newer valid commit overwrites the pending copy.
- Apply: pending copy goes to the active outputs and o_commit_pend clears when either:
  - state is IDLE (next edge), or
  - a vs falling edge is detected (vs_d=1, i_frame_vs=0).
- FSM:
  - IDLE: o_cmr_vld=0. i_enable=1 -> ARM.
  - ARM: wait for i_frame_vs=0; then o_cmr_vld=1 -> RUN. i_enable=0 -> IDLE.
  - RUN: i_enable=0 -> STOP.
  - STOP: hold o_cmr_vld=1 until a vs falling edge, then o_cmr_vld=0 -> IDLE. If already in blanking (i_frame_vs=0 on entry), go to IDLE next cycle. i_enable returning to 1 in STOP -> RUN.
- Line check in RUN/STOP:
  - Counter clears on vs rising edge and increments on i_frame_last.
  - On vs falling edge: if counter != o_image_h, pulse o_frame_err; increment o_frame_cnt.
  - Skip the check for the first frame after entering RUN (partial-frame guard).
  - The check uses o_image_h before any same-edge apply.

## Timing
- Reset values: o_image_w=MAX_W, o_image_h=MAX_H, offsets 0; o_cmr_vld=0, o_commit_pend=0, o_cfg_err=0, o_frame_err=0, o_frame_cnt=0, o_state=IDLE. Reset also clears the shadow, pending copy, line counter, vs_d and the first-frame flag.
- Commit in IDLE: active outputs change 1 cycle after the i_commit edge.
- Apply at vs fall: i_frame_vs seen low at edge n (vs_d=1) -> outputs updated at n+1; o_frame_err and o_frame_cnt update at the same edge.
- ARM -> RUN: o_cmr_vld rises 1 cycle after i_frame_vs is sampled low.
- Commit on the same cycle as a vs falling edge: the previous pending set (if any) is applied; the new set stays pending.
- Reset mid-frame: everything returns to reset values the next cycle, with no o_frame_err pulse.

## Test plan
- Reset, write w=1280, h=720, x=320, y=180 in IDLE, commit -> outputs equal these values 1 cycle later, o_cfg_err=0.
- Commit w=1921 or x=1000, w=1000 -> o_cfg_err=1 and active values unchanged; a following valid commit clears it.
- In RUN, commit h=540 mid-frame -> o_commit_pend=1, o_image_h unchanged until the cycle after vs falls, then 540.
- Enable during an active frame -> ARM holds o_cmr_vld=0 until vs=0. Drop enable mid-frame -> o_cmr_vld stays 1 until frame end, then IDLE.
- Full frames with 720 last strobes, h=720 -> no o_frame_err and o_frame_cnt increments. A frame with 719 strobes -> exactly one o_frame_err pulse. The first (partial) frame after RUN entry -> no check.
- Write and commit in the same cycle -> the commit applies the old shadow and the new value appears only after a second commit.
